// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and constants for the reset sequencer.
//   state_e      - sequencer states (ASSERT, COUNT, RUN)
//   CAUSE_*      - encodings reported on rst_cause
//   RST_COUNT_MAX - saturation value of rst_count
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_COUNT  = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POWER = 2'b00;
    localparam logic [1:0] CAUSE_PIN   = 2'b01;
    localparam logic [1:0] CAUSE_SOFT  = 2'b10;
    localparam logic [1:0] CAUSE_WDT   = 2'b11;

    localparam logic [7:0] RST_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/clk_en_divider.sv
// clk_en_divider: free-running divider producing a one-cycle clk_en strobe
// every 2^SLOW cycles while not cleared.
//   CLK    in  - clock
//   clear  in  - holds the divider at zero and suppresses clk_en
//   clk_en out - registered strobe, first pulse 2^SLOW cycles after clear drops
module clk_en_divider #(
    parameter int SLOW = 0
) (
    input  logic CLK,
    input  logic clear,
    output logic clk_en
);

    localparam int DW = (SLOW > 0) ? SLOW : 1;

    logic [DW-1:0] div_q = '0;
    logic [DW-1:0] div_d;
    logic          clk_en_q = 1'b0;
    logic          clk_en_d;

    always_comb begin
        div_d    = div_q + DW'(1);
        clk_en_d = 1'b0;
        if (clear) begin
            div_d    = '0;
            clk_en_d = 1'b0;
        end else if (SLOW == 0) begin
            // Divide-by-one: strobe on every enabled cycle.
            clk_en_d = 1'b1;
        end else begin
            clk_en_d = &div_q;
        end
    end

    always_ff @(posedge CLK) begin
        div_q    <= div_d;
        clk_en_q <= clk_en_d;
    end

    assign clk_en = clk_en_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset and clock-enable generator.
// Turns the RESET pin, a soft-reset request and an optional watchdog into a
// timed active-low resetn plus a clk_en strobe at 1/2^SLOW of CLK, and records
// the cause of the last reset.
// Optional feature macro: RESET_SEQ_WATCHDOG_EN (builds the watchdog).
//   CLK          in  - the only clock
//   RESET        in  - synchronous active-high reset, highest priority
//   soft_rst_req in  - level soft-reset request, honoured in RUN only
//   wdt_kick     in  - watchdog reload strobe (ignored without the macro)
//   resetn       out - registered active-low design reset
//   clk_en       out - registered one-cycle enable strobe
//   rst_cause    out - 00 power-up, 01 pin, 10 soft, 11 watchdog
//   rst_count    out - soft + watchdog resets, saturating at 255
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int SLOW        = 0,
    parameter int WDT_CYCLES  = 1 << 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       soft_rst_req,
    input  logic       wdt_kick,
    output logic       resetn,
    output logic       clk_en,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Register initializers give the power-up state without an external reset.
    state_e          state_q  = ST_ASSERT;
    state_e          state_d;
    logic [HW-1:0]   hold_q   = '0;
    logic [HW-1:0]   hold_d;
    logic [1:0]      cause_q  = CAUSE_POWER;
    logic [1:0]      cause_d;
    logic [7:0]      count_q  = '0;
    logic [7:0]      count_d;
    logic            resetn_q = 1'b0;
    logic            resetn_d;
    logic            wdt_expire;
    logic            div_clear;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDT_CYCLES);

    logic [WW-1:0] wdt_q = '0;
    logic [WW-1:0] wdt_d;

    always_comb begin
        wdt_d = wdt_q + WW'(1);
        if (wdt_kick || (state_q != ST_RUN)) begin
            wdt_d = '0;
        end
    end

    // A kick in the expiry cycle wins.
    assign wdt_expire = (state_q == ST_RUN) && !wdt_kick &&
                        (wdt_q == WW'(WDT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        wdt_q <= wdt_d;
    end
`else
    logic wdt_unused;
    assign wdt_unused = wdt_kick | (WDT_CYCLES < 2);
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        count_d = count_q;
        if (RESET) begin
            state_d = ST_ASSERT;
            hold_d  = '0;
            cause_d = CAUSE_PIN;
            count_d = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_d = ST_COUNT;
                    hold_d  = '0;
                end
                ST_COUNT: begin
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                ST_RUN: begin
                    // Soft request outranks the watchdog; one increment either way.
                    if (soft_rst_req || wdt_expire) begin
                        state_d = ST_ASSERT;
                        cause_d = soft_rst_req ? CAUSE_SOFT : CAUSE_WDT;
                        if (count_q != RST_COUNT_MAX) begin
                            count_d = count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
        resetn_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        state_q  <= state_d;
        hold_q   <= hold_d;
        cause_q  <= cause_d;
        count_q  <= count_d;
        resetn_q <= resetn_d;
    end

    // Clearing on either side of the transition keeps the divider at zero on the
    // edge RUN is entered (first strobe exactly 2^SLOW later) and blocks a strobe
    // from leaking into the first ASSERT cycle when RUN is left.
    assign div_clear = (state_q != ST_RUN) || (state_d != ST_RUN);

    clk_en_divider #(
        .SLOW (SLOW)
    ) u_div (
        .CLK    (CLK),
        .clear  (div_clear),
        .clk_en (clk_en)
    );

    assign resetn    = resetn_q;
    assign rst_cause = cause_q;
    assign rst_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed self-checking bench for reset_sequencer with
// HOLD_CYCLES = 4, SLOW = 2, WDT_CYCLES = 8. Watchdog checks depend on
// RESET_SEQ_WATCHDOG_EN; without it the bench checks that no watchdog reset occurs.
module tb_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       wdt_kick = 1'b1;
    logic       resetn;
    logic       clk_en;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    int nvec = 0;
    int nerr = 0;

    reset_sequencer #(
        .HOLD_CYCLES (4),
        .SLOW        (2),
        .WDT_CYCLES  (8)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .resetn       (resetn),
        .clk_en       (clk_en),
        .rst_cause    (rst_cause),
        .rst_count    (rst_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One soft reset from RUN, back in RUN afterwards.
    task automatic soft_pulse();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int n;
        int exp_cnt;

        // Power-up values before any edge.
        #1;
        check("pwr_resetn", resetn, 0);
        check("pwr_clk_en", clk_en, 0);
        check("pwr_cause", rst_cause, 2'b00);
        check("pwr_count", rst_count, 0);

        // Release: hold RESET three edges, then release.
        RESET = 1'b1;
        repeat (3) tick();
        check("rst_resetn", resetn, 0);
        check("rst_cause", rst_cause, 2'b01);
        check("rst_count", rst_count, 0);
        RESET = 1'b0;
        tick();                               // E0
        check("e0_resetn", resetn, 0);
        repeat (3) tick();                    // E0+3
        check("e3_resetn", resetn, 0);
        check("e3_clk_en", clk_en, 0);
        tick();                               // E0+4
        check("e4_resetn", resetn, 1);
        check("e4_cause", rst_cause, 2'b01);
        check("e4_clk_en", clk_en, 0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("div_low", clk_en, 0);
            end
            tick();
            check("div_high", clk_en, 1);
        end

        // Soft reset pulse: low for 5 cycles.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("soft_resetn", resetn, 0);
        check("soft_clk_en", clk_en, 0);
        check("soft_cause", rst_cause, 2'b10);
        check("soft_count", rst_count, 1);
        n = 1;
        while (resetn === 1'b0 && n < 20) begin
            tick();
            if (resetn === 1'b0) n++;
        end
        check("soft_low_cycles", n, 5);

        // Soft request held through ASSERT/COUNT: a single increment.
        soft_rst_req = 1'b1;
        tick();
        check("held_count_a", rst_count, 2);
        repeat (5) tick();
        soft_rst_req = 1'b0;
        check("held_resetn", resetn, 1);
        check("held_count_b", rst_count, 2);

        // RESET and soft request together: pin wins, count clears.
        RESET = 1'b1;
        soft_rst_req = 1'b1;
        tick();
        RESET = 1'b0;
        soft_rst_req = 1'b0;
        check("both_cause", rst_cause, 2'b01);
        check("both_count", rst_count, 0);
        check("both_resetn", resetn, 0);

        // RESET mid-COUNT restarts hold timing from E0.
        repeat (3) tick();                    // E0 then two COUNT edges
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_resetn", resetn, 0);
        tick();                               // new E0
        repeat (3) tick();
        check("mid_e3_resetn", resetn, 0);
        tick();
        check("mid_e4_resetn", resetn, 1);
        exp_cnt = 0;

`ifdef RESET_SEQ_WATCHDOG_EN
        // No kick: reset fires on the 8th RUN cycle.
        wdt_kick = 1'b0;
        repeat (7) tick();
        check("wdt_pre_resetn", resetn, 1);
        tick();
        check("wdt_resetn", resetn, 0);
        check("wdt_cause", rst_cause, 2'b11);
        exp_cnt = 1;
        check("wdt_count", rst_count, exp_cnt);
        wdt_kick = 1'b1;
        repeat (5) tick();
        check("wdt_rerun", resetn, 1);
        // Kick during RUN cycle 7 prevents expiry.
        wdt_kick = 1'b0;
        repeat (6) tick();
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        tick();
        check("kick_resetn", resetn, 1);
        // Soft and watchdog in the same cycle.
        repeat (6) tick();
        check("sim_pre_resetn", resetn, 1);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        wdt_kick = 1'b1;
        check("sim_cause", rst_cause, 2'b10);
        exp_cnt = 2;
        check("sim_count", rst_count, exp_cnt);
        repeat (5) tick();
        check("sim_rerun", resetn, 1);
`else
        // No watchdog built: no kicks must not cause a reset.
        wdt_kick = 1'b0;
        repeat (20) tick();
        check("nowdt_resetn", resetn, 1);
        check("nowdt_cause", rst_cause, 2'b01);
        check("nowdt_count", rst_count, 0);
        wdt_kick = 1'b1;
`endif

        // Saturation over 260 soft resets.
        for (int i = 0; i < 260; i++) begin
            soft_pulse();
            if (exp_cnt < 255) exp_cnt++;
            if (i == 100) check("sat_mid", rst_count, exp_cnt);
        end
        check("sat_count", rst_count, 255);
        check("sat_cause", rst_cause, 2'b10);
        check("sat_resetn", resetn, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset and clock-enable generator for the top of the design. It turns the board `RESET` pin, a design-side soft-reset request and an optional watchdog into a timed active-low `resetn` and a `clk_en` strobe at 1/2^SLOW of `CLK`. Downstream logic runs on `CLK` and qualifies its work with `clk_en`, so no derived clock is needed. It also records why the last reset happened.

## Interface
Parameters:
- `HOLD_CYCLES`, default 16: number of `CLK` cycles `resetn` stays low after a reset source is released; legal range is 1 or more.
- `SLOW`, default 0: sets the `clk_en` period to 2^SLOW cycles.
- `WDT_CYCLES`, default 2^20: watchdog timeout in `CLK` cycles; legal range is 2 or more.

Ports:
- `CLK` in 1: the only clock.
- `RESET` in 1: synchronous, active-high reset; it has priority over everything else.
- `soft_rst_req` in 1: level input, sampled on `CLK` edges; requests a reset sequence.
- `wdt_kick` in 1: watchdog reload strobe.
- `resetn` out 1: registered active-low reset for the design.
- `clk_en` out 1: registered one-cycle enable strobe.
- `rst_cause` out 2: last reset cause. 00 = power-up, 01 = `RESET`, 10 = soft, 11 = watchdog.
- `rst_count` out 8: number of soft and watchdog resets; saturates at 255.

## Operation
- **States:**
  - ASSERT: `resetn` = 0.
  - COUNT: `resetn` = 0; hold counter running.
  - RUN: `resetn` = 1.
- **Power-up:** register initializers put the block in ASSERT, with `resetn` = 0, `clk_en` = 0, `rst_cause` = 00 and `rst_count` = 0. No external reset is needed.
- **`RESET` = 1 (any state):** next state is ASSERT, `rst_cause` = 01, `rst_count` = 0, hold counter = 0, divider = 0. The block stays in ASSERT while `RESET` is high.
- **ASSERT with `RESET` = 0:** go to COUNT with hold counter = 0.
- **COUNT:** the hold counter increments each cycle. On the edge where it equals HOLD_CYCLES−1, go to RUN. `soft_rst_req` and the watchdog are ignored in this state.
- **RUN with `soft_rst_req` = 1:** go to ASSERT for exactly one cycle, then COUNT. Set `rst_cause` = 10. Increment `rst_count`, saturating at 255.
- **Watchdog expiry in RUN:** same behaviour as a soft request, but `rst_cause` = 11.
- **Priority:** `RESET` first, then soft request, then watchdog. When soft and watchdog occur in the same cycle, `rst_cause` = 10 and `rst_count` increments once.
- **Divider:**
  - Width is max(SLOW,1) bits. It is cleared whenever the state is not RUN and increments every cycle in RUN.
  - `clk_en` = 1 on the cycle after the divider reaches all-ones.
  - With SLOW = 0, `clk_en` = 1 on every cycle in RUN.
  - `clk_en` = 0 in ASSERT and COUNT.
- **Watchdog counter:**
  - Reloads to 0 on `wdt_kick`, and whenever the state is not RUN.
  - Increments otherwise.
  - Expires when it equals WDT_CYCLES−1 in RUN.
  - A kick in the expiry cycle wins, so no reset occurs.

## Timing
- Let E0 be the first edge that samples `RESET` = 0 while in ASSERT. `resetn` rises at edge E0+HOLD_CYCLES, so it is low for HOLD_CYCLES+1 cycles after `RESET` falls.
- A soft request sampled at edge S drops `resetn` after S and raises it after S+1+HOLD_CYCLES.
- `rst_cause` and `rst_count` update on the same edge as the transition into ASSERT.
- The first `clk_en` after entering RUN occurs 2^SLOW cycles after `resetn` rises. `clk_en` then repeats every 2^SLOW cycles.
- `RESET` asserted mid-COUNT or mid-RUN takes effect on the next edge. The sequence then restarts from E0.
- All outputs are registered; no combinational path runs from any input to any output.

## Configuration
- Macro: `RESET_SEQ_WATCHDOG_EN`.
- **Defined:** the watchdog counter and expiry are built, and cause 11 is possible.
- **Undefined:** there is no watchdog logic. `wdt_kick` stays in the port list but is ignored, and `rst_cause` never reads 11.

## Structure
- Shared package `reset_seq_pkg` holds:
  - the state encoding (ASSERT, COUNT, RUN);
  - the cause constants CAUSE_POWER, CAUSE_PIN, CAUSE_SOFT and CAUSE_WDT.
- Sub-module `clk_en_divider`: parameter SLOW, inputs `CLK` and `clear`, output `clk_en`. The FSM drives `clear` with (state != RUN).

## Test plan
- **Release:** HOLD_CYCLES = 4, SLOW = 2; hold `RESET` 3 cycles, then release.
  - `resetn` rises exactly 4 edges after E0 and `rst_cause` = 01.
  - The first `clk_en` arrives 4 cycles later and then repeats every 4 cycles.
- **Soft reset:** pulse `soft_rst_req` one cycle in RUN.
  - `resetn` is low for 5 cycles, `rst_cause` = 10 and `rst_count` = 1.
  - Holding `soft_rst_req` high through COUNT causes no extra increment.
- **Watchdog:** with the macro defined and WDT_CYCLES = 8, do not kick in RUN.
  - Reset fires on the 8th RUN cycle with `rst_cause` = 11.
  - A kick at cycle 7 prevents it.
- **Simultaneous sources:**
  - Soft request and watchdog expiry in the same cycle give `rst_cause` = 10 and `rst_count` +1.
  - `RESET` plus a soft request in the same cycle give `rst_cause` = 01 and `rst_count` = 0.
- **Saturation and mid-sequence reset:**
  - 260 soft resets leave `rst_count` = 255.
  - Asserting `RESET` mid-COUNT restarts the hold timing from E0.
